// File: rtl/mat_deinterleave_n.sv
// mat_deinterleave_n: routes groups of GROUP_LEN input beats round-robin to N_CH
// output channels through a single registered holding stage. The routing realigns
// to channel 0 at every frame boundary, and a sticky flag reports frames that end
// mid-group or on the wrong channel.
module mat_deinterleave_n #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned N_CH      = 2,
    parameter int unsigned GROUP_LEN = 3,
    localparam int unsigned CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int unsigned BEAT_W   = (GROUP_LEN > 1) ? $clog2(GROUP_LEN) : 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clk_e,
    input  logic [DATA_W-1:0] s_axis_data,
    input  logic              s_axis_valid,
    input  logic              s_axis_last,
    output logic              s_axis_ready,
    output logic [DATA_W-1:0] m_axis_data,
    output logic [N_CH-1:0]   m_axis_valid,
    output logic              m_axis_last,
    input  logic [N_CH-1:0]   m_axis_ready,
    output logic [CH_W-1:0]   o_ch_sel,
    output logic              o_frame_err
);

    localparam logic [CH_W-1:0]   ChMax   = CH_W'(N_CH - 1);
    localparam logic [BEAT_W-1:0] BeatMax = BEAT_W'(GROUP_LEN - 1);

    logic              out_v;
    logic [CH_W-1:0]   out_ch;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic [BEAT_W-1:0] beat_cnt;
    logic [CH_W-1:0]   ch_sel;
    logic              frame_err;

    logic              sel_ready;
    logic [N_CH-1:0]   valid_vec;
    logic              in_fire;
    logic              out_fire;
    logic              group_end;
    logic              last_ch;

    // Decode the held beat's channel into a valid vector and pick that channel's ready.
    always_comb begin
        sel_ready = 1'b0;
        valid_vec = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (out_ch == CH_W'(k)) begin
                sel_ready    = m_axis_ready[k];
                valid_vec[k] = i_clk_e & out_v;
            end
        end
    end

    // Ready is combinational from the holding register so a draining beat can be
    // replaced in the same cycle, giving one beat per cycle throughput.
    assign s_axis_ready = i_clk_e & (~out_v | sel_ready);
    assign in_fire      = s_axis_valid & s_axis_ready;
    assign out_fire     = i_clk_e & out_v & sel_ready;
    assign group_end    = (beat_cnt == BeatMax);
    assign last_ch      = (ch_sel == ChMax);

    assign m_axis_valid = valid_vec;
    assign m_axis_data  = out_data;
    assign m_axis_last  = out_last;
    assign o_ch_sel     = ch_sel;
    assign o_frame_err  = frame_err;

    // Holding register: a new beat overrides the drain of the old one (pass-through).
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            out_v    <= 1'b0;
            out_ch   <= '0;
            out_data <= '0;
            out_last <= 1'b0;
        end else if (i_clk_e) begin
            if (in_fire) begin
                out_v    <= 1'b1;
                out_ch   <= ch_sel;
                out_data <= s_axis_data;
                out_last <= s_axis_last;
            end else if (out_fire) begin
                out_v <= 1'b0;
            end
        end
    end

    // Routing counters and sticky frame error; last realigns to channel 0 first.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            beat_cnt  <= '0;
            ch_sel    <= '0;
            frame_err <= 1'b0;
        end else if (i_clk_e && in_fire) begin
            if (s_axis_last) begin
                beat_cnt <= '0;
                ch_sel   <= '0;
                if (!(group_end && last_ch)) begin
                    frame_err <= 1'b1;
                end
            end else if (group_end) begin
                beat_cnt <= '0;
                ch_sel   <= last_ch ? '0 : ch_sel + 1'b1;
            end else begin
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mat_deinterleave_n.sv
// Testbench for mat_deinterleave_n: a 2-channel/group-3 instance and a
// 3-channel/group-1 instance, checked against a scoreboard of expected beats.
module tb_mat_deinterleave_n;

    logic        clk;
    logic        rst;
    logic        ce;

    logic [15:0] a_sd;
    logic        a_sv;
    logic        a_sl;
    logic        a_sr;
    logic [15:0] a_md;
    logic [1:0]  a_mv;
    logic        a_ml;
    logic [1:0]  a_mr;
    logic [0:0]  a_chsel;
    logic        a_ferr;

    logic [15:0] b_sd;
    logic        b_sv;
    logic        b_sl;
    logic        b_sr;
    logic [15:0] b_md;
    logic [2:0]  b_mv;
    logic        b_ml;
    logic [2:0]  b_mr;
    logic [1:0]  b_chsel;
    logic        b_ferr;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int data;
        int ch;
        bit last;
        int cyc;
    } exp_t;

    exp_t sb[$];

    mat_deinterleave_n #(.DATA_W(16), .N_CH(2), .GROUP_LEN(3)) dut_a (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_clk_e      (ce),
        .s_axis_data  (a_sd),
        .s_axis_valid (a_sv),
        .s_axis_last  (a_sl),
        .s_axis_ready (a_sr),
        .m_axis_data  (a_md),
        .m_axis_valid (a_mv),
        .m_axis_last  (a_ml),
        .m_axis_ready (a_mr),
        .o_ch_sel     (a_chsel),
        .o_frame_err  (a_ferr)
    );

    mat_deinterleave_n #(.DATA_W(16), .N_CH(3), .GROUP_LEN(1)) dut_b (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_clk_e      (ce),
        .s_axis_data  (b_sd),
        .s_axis_valid (b_sv),
        .s_axis_last  (b_sl),
        .s_axis_ready (b_sr),
        .m_axis_data  (b_md),
        .m_axis_valid (b_mv),
        .m_axis_last  (b_ml),
        .m_axis_ready (b_mr),
        .o_ch_sel     (b_chsel),
        .o_frame_err  (b_ferr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst  = 1'b1;
        ce   = 1'b1;
        a_sv = 1'b0; a_sd = '0; a_sl = 1'b0; a_mr = 2'b11;
        b_sv = 1'b0; b_sd = '0; b_sl = 1'b0; b_mr = 3'b111;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Reset is applied with the clock enable low: it must still take effect.
    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        ce  = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        ce  = 1'b1;
        #1;
        checks++;
        if (a_mv !== 2'b00 || a_ml !== 1'b0 || a_md !== 16'd0 || a_chsel !== 1'b0 ||
            a_ferr !== 1'b0 || a_sr !== 1'b1) begin
            failures++;
            $display("FAIL reset_a: mv=%b ml=%b md=%0d ch=%b err=%b rdy=%b, want 00 0 0 0 0 1",
                     a_mv, a_ml, a_md, a_chsel, a_ferr, a_sr);
        end
        checks++;
        if (b_mv !== 3'b000 || b_ml !== 1'b0 || b_md !== 16'd0 || b_chsel !== 2'b00 ||
            b_ferr !== 1'b0 || b_sr !== 1'b1) begin
            failures++;
            $display("FAIL reset_b: mv=%b ml=%b md=%0d ch=%b err=%b rdy=%b, want 000 0 0 0 0 1",
                     b_mv, b_ml, b_md, b_chsel, b_ferr, b_sr);
        end
    endtask

    // Streams beats 1..nbeats into instance A with last on last_beat.
    // mode 0: all ready; 1: channel 1 stalled 5 cycles on beat 4; 2: clock-enable gaps;
    // 3: early last (all ready).
    task automatic test_stream_a(input int mode, input int nbeats, input int last_beat);
        int   sent;
        int   cyc;
        int   m_ch;
        int   m_cnt;
        int   stall_left;
        int   prev_out_cyc;
        int   obs_ch;
        bit   m_err;
        bit   done;
        exp_t e;
        do_reset();
        sb.delete();
        sent = 0; m_ch = 0; m_cnt = 0; m_err = 1'b0; done = 1'b0;
        stall_left = (mode == 1) ? 5 : 0;
        prev_out_cyc = -10;
        cyc = 0;
        while (!done && cyc < 300) begin
            @(negedge clk);
            ce = (mode == 2) ? (cyc % 2 == 0) : 1'b1;
            #1;
            checks++;
            if (a_chsel !== 1'(m_ch) || a_ferr !== m_err) begin
                failures++;
                $display("FAIL state_m%0d cyc %0d: ch_sel=%b err=%b, want %0d %0b",
                         mode, cyc, a_chsel, a_ferr, m_ch, m_err);
            end
            a_mr = 2'b11;
            if (mode == 1 && stall_left > 0 && a_mv == 2'b10 && a_md == 16'd4) begin
                a_mr = 2'b01;
                stall_left--;
            end
            if (sent < nbeats) begin
                a_sv = 1'b1;
                a_sd = 16'(sent + 1);
                a_sl = (sent + 1 == last_beat);
            end else begin
                a_sv = 1'b0;
                a_sd = '0;
                a_sl = 1'b0;
            end
            #1;
            if (!ce) begin
                checks++;
                if (a_mv !== 2'b00 || a_sr !== 1'b0) begin
                    failures++;
                    $display("FAIL ce_gap cyc %0d: mv=%b rdy=%b, want 00 0", cyc, a_mv, a_sr);
                end
            end
            if (mode == 1 && a_mr == 2'b01) begin
                checks++;
                if (a_mv !== 2'b10 || a_md !== 16'd4 || a_sr !== 1'b0) begin
                    failures++;
                    $display("FAIL stall_hold cyc %0d: mv=%b md=%0d rdy=%b, want 10 4 0",
                             cyc, a_mv, a_md, a_sr);
                end
            end
            if ((a_mv & a_mr) != 2'b00) begin
                obs_ch = a_mv[1] ? 1 : 0;
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL extra_beat_m%0d: got data %0d, want nothing", mode, a_md);
                end else begin
                    e = sb.pop_front();
                    if (a_mv == 2'b11 || a_md !== 16'(e.data) || obs_ch != e.ch ||
                        a_ml !== e.last) begin
                        failures++;
                        $display("FAIL beat_m%0d: mv=%b data=%0d ch=%0d last=%b, want %0d %0d %0b",
                                 mode, a_mv, a_md, obs_ch, a_ml, e.data, e.ch, e.last);
                    end
                    if (mode == 0 || mode == 3) begin
                        checks++;
                        if (cyc != e.cyc + 1) begin
                            failures++;
                            $display("FAIL latency data %0d: %0d cycles, want 1",
                                     e.data, cyc - e.cyc);
                        end
                    end
                    if (mode == 1 && (e.data == 5 || e.data == 6)) begin
                        checks++;
                        if (cyc != prev_out_cyc + 1) begin
                            failures++;
                            $display("FAIL after_release data %0d: gap %0d, want 1",
                                     e.data, cyc - prev_out_cyc);
                        end
                    end
                end
                prev_out_cyc = cyc;
            end
            if (a_sv && a_sr) begin
                e.data = sent + 1;
                e.ch   = m_ch;
                e.last = a_sl;
                e.cyc  = cyc;
                sb.push_back(e);
                sent++;
                if (a_sl) begin
                    if (!(m_cnt == 2 && m_ch == 1)) m_err = 1'b1;
                    m_cnt = 0;
                    m_ch  = 0;
                end else if (m_cnt == 2) begin
                    m_cnt = 0;
                    m_ch  = (m_ch == 1) ? 0 : m_ch + 1;
                end else begin
                    m_cnt++;
                end
            end
            if (sent == nbeats && sb.size() == 0) done = 1'b1;
            cyc++;
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL timeout_m%0d: sent=%0d pending=%0d, want all drained",
                     mode, sent, sb.size());
        end
        @(negedge clk);
        ce   = 1'b1;
        a_sv = 1'b0;
        #1;
        checks++;
        if (a_mv !== 2'b00 || a_chsel !== 1'(m_ch) || a_ferr !== (mode == 3)) begin
            failures++;
            $display("FAIL end_m%0d: mv=%b ch_sel=%b err=%b, want 00 %0d %0d",
                     mode, a_mv, a_chsel, a_ferr, m_ch, (mode == 3));
        end
    endtask

    task automatic test_stream();
        test_stream_a(0, 12, 12);
    endtask

    task automatic test_backpressure();
        test_stream_a(1, 12, 12);
    endtask

    task automatic test_ce_gaps();
        test_stream_a(2, 12, 12);
    endtask

    task automatic test_early_last();
        test_stream_a(3, 7, 4);
    endtask

    // Instance B: GROUP_LEN=1, channel order 0,1,2,0,1,2 and ch_sel wrap 2 -> 0.
    task automatic test_group1();
        int   sent;
        int   cyc;
        int   m_ch;
        int   obs_ch;
        bit   done;
        exp_t e;
        do_reset();
        sb.delete();
        sent = 0; m_ch = 0; done = 1'b0; cyc = 0;
        while (!done && cyc < 100) begin
            @(negedge clk);
            #1;
            checks++;
            if (b_chsel !== 2'(m_ch) || b_ferr !== 1'b0) begin
                failures++;
                $display("FAIL g1_state cyc %0d: ch_sel=%0d err=%b, want %0d 0",
                         cyc, b_chsel, b_ferr, m_ch);
            end
            if (sent < 6) begin
                b_sv = 1'b1;
                b_sd = 16'(sent + 1);
                b_sl = (sent == 5);
            end else begin
                b_sv = 1'b0;
                b_sd = '0;
                b_sl = 1'b0;
            end
            #1;
            if (b_mv != 3'b000) begin
                obs_ch = b_mv[2] ? 2 : (b_mv[1] ? 1 : 0);
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL g1_extra: got data %0d, want nothing", b_md);
                end else begin
                    e = sb.pop_front();
                    if ($countones(b_mv) != 1 || b_md !== 16'(e.data) || obs_ch != e.ch ||
                        b_ml !== e.last) begin
                        failures++;
                        $display("FAIL g1_beat: mv=%b data=%0d ch=%0d last=%b, want %0d %0d %0b",
                                 b_mv, b_md, obs_ch, b_ml, e.data, e.ch, e.last);
                    end
                end
            end
            if (b_sv && b_sr) begin
                e.data = sent + 1;
                e.ch   = sent % 3;
                e.last = b_sl;
                e.cyc  = cyc;
                sb.push_back(e);
                sent++;
                m_ch = (sent == 6) ? 0 : sent % 3;
            end
            if (sent == 6 && sb.size() == 0) done = 1'b1;
            cyc++;
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL g1_timeout: sent=%0d pending=%0d, want all drained", sent, sb.size());
        end
        @(negedge clk);
        b_sv = 1'b0;
    endtask

    // Reset while beat 6 is held on ch1 with beat_cnt=2 and the error flag set.
    task automatic test_mid_reset();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            a_sv = 1'b1;
            a_sd = 16'(i + 1);
            a_sl = (i == 0);
        end
        @(negedge clk);
        a_sv = 1'b0;
        a_sl = 1'b0;
        #1;
        checks++;
        if (a_mv !== 2'b10 || a_md !== 16'd6 || a_chsel !== 1'b1 || a_ferr !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset: mv=%b md=%0d ch_sel=%b err=%b, want 10 6 1 1",
                     a_mv, a_md, a_chsel, a_ferr);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (a_mv !== 2'b00 || a_md !== 16'd0 || a_chsel !== 1'b0 || a_ferr !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset: mv=%b md=%0d ch_sel=%b err=%b, want 00 0 0 0",
                     a_mv, a_md, a_chsel, a_ferr);
        end
        for (int j = 0; j < 5; j++) begin
            if (j > 0) begin
                #1;
                checks++;
                if (a_mv !== ((j <= 3) ? 2'b01 : 2'b10) || a_md !== 16'(98 + j)) begin
                    failures++;
                    $display("FAIL post_reset beat %0d: mv=%b md=%0d, want %b %0d",
                             j - 1, a_mv, a_md, (j <= 3) ? 2'b01 : 2'b10, 98 + j);
                end
            end
            a_sv = (j < 4);
            a_sd = 16'(99 + j);
            a_sl = 1'b0;
            @(negedge clk);
        end
        a_sv = 1'b0;
    endtask

    initial begin
        rst  = 1'b0;
        ce   = 1'b1;
        a_sv = 1'b0; a_sd = '0; a_sl = 1'b0; a_mr = 2'b11;
        b_sv = 1'b0; b_sd = '0; b_sl = 1'b0; b_mr = 3'b111;
        test_reset();
        test_stream();
        test_backpressure();
        test_ce_gaps();
        test_early_last();
        test_group1();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
